// File: rtl/xbar_output_stage.sv
// Router crossbar output stage: per-output show-ahead FIFOs fed by the mux selects, with
// registered upstream stall, per-input acks and sticky per-output timeout failure.
module xbar_out_port #(
  parameter int DW      = 40,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          sel,
  input  logic [2:0][DW-1:0]  din_all,
  input  logic                stall,
  input  logic                ready,
  output logic [DW-1:0]       dout,
  output logic                valid,
  output logic                fail,
  output logic [2:0]          push_src,
  output logic                stall_req
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [TW-1:0] tcnt;
  logic          fail_q, fail_nxt, push, pop, blocked;
  logic [DW-1:0] wdata;

  assign valid     = (count != '0) && !fail_q;
  assign pop       = valid & ready;
  assign blocked   = valid & ~ready;
  assign push      = (sel != 2'b00) && !stall && !fail_q && (count != CW'(DEPTH));
  assign fail_nxt  = fail_q | (blocked && (tcnt == TW'(TIMEOUT - 1)));
  assign fail      = fail_q;
  assign dout      = valid ? mem[rd_ptr] : '0;
  // A port that is failing this cycle is already excluded from the stall decision.
  assign stall_req = !fail_nxt && (count_nxt >= CW'(DEPTH - 1));

  always_comb begin
    wdata    = din_all[0];
    push_src = '0;
    case (sel)
      2'b01: begin wdata = din_all[0]; push_src = {2'b00, push}; end
      2'b10: begin wdata = din_all[1]; push_src = {1'b0, push, 1'b0}; end
      2'b11: begin wdata = din_all[2]; push_src = {push, 2'b00}; end
      default: ;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (fail_q) count_nxt = '0;
    else if (push && !pop) count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      tcnt   <= '0;
      fail_q <= 1'b0;
    end else begin
      fail_q <= fail_nxt;
      count  <= count_nxt;
      if (fail_q) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      if (!blocked) tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT)) tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end
endmodule

module xbar_output_stage #(
  parameter int DW      = 40,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    control_x,
  input  logic [1:0]    control_y,
  input  logic [1:0]    control_local,
  input  logic [DW-1:0] din_x,
  input  logic [DW-1:0] din_y,
  input  logic [DW-1:0] din_local,
  output logic [DW-1:0] dout_x,
  output logic [DW-1:0] dout_y,
  output logic [DW-1:0] dout_local,
  output logic [2:0]    dout_valid,
  input  logic [2:0]    dout_ready,
  output logic [2:0]    ack,
  output logic [2:0]    fail,
  output logic          control_clk
);
  logic [2:0][1:0]    sel_all;
  logic [2:0][DW-1:0] din_all, dout_all;
  logic [2:0][2:0]    push_src;
  logic [2:0]         stall_req;
  logic [2:0]         ack_nxt;

  assign sel_all    = {control_local, control_y, control_x};
  assign din_all    = {din_local, din_y, din_x};
  assign dout_x     = dout_all[0];
  assign dout_y     = dout_all[1];
  assign dout_local = dout_all[2];
  assign ack_nxt    = push_src[0] | push_src[1] | push_src[2];

  for (genvar p = 0; p < 3; p++) begin : g_port
    xbar_out_port #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .sel       (sel_all[p]),
      .din_all   (din_all),
      .stall     (control_clk),
      .ready     (dout_ready[p]),
      .dout      (dout_all[p]),
      .valid     (dout_valid[p]),
      .fail      (fail[p]),
      .push_src  (push_src[p]),
      .stall_req (stall_req[p])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack         <= '0;
      control_clk <= 1'b0;
    end else begin
      ack         <= ack_nxt;
      control_clk <= |stall_req;
    end
  end
endmodule

// File: tb/tb_xbar_output_stage.sv
// Directed + short random bench for xbar_output_stage; a queue-per-output scoreboard
// predicts every flit, ack, stall and fail value.
module tb_xbar_output_stage;
  localparam int DW = 40, DEPTH = 4, TIMEOUT = 15;

  logic          clk = 0, rst_n = 0;
  logic [1:0]    control_x = 0, control_y = 0, control_local = 0;
  logic [DW-1:0] din_x = 0, din_y = 0, din_local = 0;
  logic [DW-1:0] dout_x, dout_y, dout_local;
  logic [2:0]    dout_valid, ack, fail;
  logic [2:0]    dout_ready = 3'b111;
  logic          control_clk;

  xbar_output_stage #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .control_x(control_x), .control_y(control_y), .control_local(control_local),
    .din_x(din_x), .din_y(din_y), .din_local(din_local),
    .dout_x(dout_x), .dout_y(dout_y), .dout_local(dout_local),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .ack(ack), .fail(fail), .control_clk(control_clk)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] mq [3][$];
  int            mt [3];
  logic [2:0]    mf = 0, m_ack = 0;
  bit            m_stall = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [2:0]    ev;
    logic [DW-1:0] eh [3];
    for (int p = 0; p < 3; p++) begin
      ev[p] = (mq[p].size() != 0) && !mf[p];
      eh[p] = ev[p] ? mq[p][0] : '0;
    end
    chk("dout_valid", 64'(dout_valid), 64'(ev));
    chk("dout_x", 64'(dout_x), 64'(eh[0]));
    chk("dout_y", 64'(dout_y), 64'(eh[1]));
    chk("dout_local", 64'(dout_local), 64'(eh[2]));
    chk("ack", 64'(ack), 64'(m_ack));
    chk("fail", 64'(fail), 64'(mf));
    chk("control_clk", 64'(control_clk), 64'(m_stall));
  endtask

  // One clock: predict from current inputs/model state, advance, then compare.
  task automatic step();
    logic [1:0]    s [3];
    logic [DW-1:0] d [3];
    logic [2:0]    v, pop, push, full, nack;
    s = '{control_x, control_y, control_local};
    d = '{din_x, din_y, din_local};
    if (!rst_n) begin
      for (int p = 0; p < 3; p++) begin mq[p].delete(); mt[p] = 0; end
      mf = 0; m_ack = 0; m_stall = 0;
    end else begin
      nack = 0;
      for (int p = 0; p < 3; p++) begin
        v[p]    = (mq[p].size() != 0) && !mf[p];
        pop[p]  = v[p] & dout_ready[p];
        push[p] = (s[p] != 2'b00) && !m_stall && !mf[p];
        full[p] = mq[p].size() >= DEPTH;
        if (push[p] && !full[p]) nack[s[p] - 2'd1] = 1'b1;
      end
      for (int p = 0; p < 3; p++) begin
        if (pop[p]) void'(mq[p].pop_front());
        if (push[p] && !full[p]) mq[p].push_back(d[s[p] - 2'd1]);
        if (v[p] && !dout_ready[p]) begin
          if (mt[p] == TIMEOUT - 1) mf[p] = 1'b1;
          mt[p]++;
        end else mt[p] = 0;
        if (mf[p]) mq[p].delete();
      end
      m_ack = nack;
      m_stall = 0;
      for (int p = 0; p < 3; p++)
        if (!mf[p] && mq[p].size() >= DEPTH - 1) m_stall = 1;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    // reset, two cycles
    rst_n = 0; dout_ready = 3'b111;
    step(); step();
    rst_n = 1;

    // unicast x -> y
    control_y = 2'b01; din_x = 40'h12345;
    step();
    control_y = 2'b00;
    step(); step();

    // multicast local -> x and local
    control_x = 2'b11; control_local = 2'b11; din_local = 40'hA5;
    step();
    control_x = 2'b00; control_local = 2'b00;
    step(); step();

    // backpressure on x until the stall engages, then drain in order
    dout_ready = 3'b110;
    for (int i = 0; i < 8; i++) begin
      control_x = 2'b01; din_x = 40'h100 + 40'(i);
      step();
    end
    control_x = 2'b00; dout_ready = 3'b111;
    repeat (6) step();

    // timeout on y; later pushes ignored; only reset clears fail
    dout_ready = 3'b101;
    control_y = 2'b01; din_x = 40'h55;
    step();
    control_y = 2'b00;
    repeat (17) step();
    control_y = 2'b10; din_y = 40'h77;
    repeat (3) step();
    control_y = 2'b00; dout_ready = 3'b111;
    step();
    rst_n = 0; step(); rst_n = 1;
    step();

    // reset mid-stream with three flits queued on x
    dout_ready = 3'b110;
    for (int i = 0; i < 3; i++) begin
      control_x = 2'b01; din_x = 40'h200 + 40'(i);
      step();
    end
    control_x = 2'b00;
    rst_n = 0; step(); rst_n = 1;
    dout_ready = 3'b111;
    step();

    // short random mix: pointer wrap, multicast, mixed ready
    for (int i = 0; i < 60; i++) begin
      control_x     = 2'($urandom_range(0, 3));
      control_y     = 2'($urandom_range(0, 3));
      control_local = 2'($urandom_range(0, 3));
      din_x         = {8'($urandom), $urandom};
      din_y         = {8'($urandom), $urandom};
      din_local     = {8'($urandom), $urandom};
      for (int b = 0; b < 3; b++) dout_ready[b] = ($urandom_range(0, 3) != 0);
      step();
    end
    control_x = 0; control_y = 0; control_local = 0; dout_ready = 3'b111;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
